// File: rtl/sim_dev_arbiter.sv
// sim_dev_arbiter
//   Round-robin arbiter that shares one SimDev-style device port among NREQ
//   upstream requesters (fetch, data memory, MMIO, ...). Exactly one
//   transaction is outstanding at a time: the winning request is registered,
//   issued downstream, and its single-beat response is routed back to the
//   requester that owns the transaction.
//
// Ports
//   clock, reset              system clock, synchronous active-high reset
//   in_req_*   (per req)      upstream request channels, 32-bit fields packed
//                             requester i at [32i+31:32i], wstrb at [4i+3:4i]
//   in_resp_*                 upstream response channels; data is shared
//   out_req_*                 registered request toward the device
//   out_resp_*                device response channel
module sim_dev_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                clock,
  input  logic                reset,
  output logic [NREQ-1:0]     in_req_ready,
  input  logic [NREQ-1:0]     in_req_valid,
  input  logic [NREQ-1:0]     in_req_bits_is_cached,
  input  logic [NREQ-1:0]     in_req_bits_is_aligned,
  input  logic [32*NREQ-1:0]  in_req_bits_addr,
  input  logic [32*NREQ-1:0]  in_req_bits_data,
  input  logic [NREQ-1:0]     in_req_bits_func,
  input  logic [4*NREQ-1:0]   in_req_bits_wstrb,
  input  logic [NREQ-1:0]     in_resp_ready,
  output logic [NREQ-1:0]     in_resp_valid,
  output logic [31:0]         in_resp_bits_data,
  input  logic                out_req_ready,
  output logic                out_req_valid,
  output logic                out_req_bits_is_cached,
  output logic                out_req_bits_is_aligned,
  output logic                out_req_bits_func,
  output logic [31:0]         out_req_bits_addr,
  output logic [31:0]         out_req_bits_data,
  output logic [3:0]          out_req_bits_wstrb,
  output logic                out_resp_ready,
  input  logic                out_resp_valid,
  input  logic [31:0]         out_resp_bits_data
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               cached_q, cached_d;
  logic               aligned_q, aligned_d;
  logic               func_q, func_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic [3:0]         wstrb_q, wstrb_d;

  // Round-robin winner: the first valid index at or above rr_ptr wins; if
  // there is none, wrap around and take the lowest valid index.
  logic               any_valid;
  logic               hi_found;
  logic [IDX_W-1:0]   hi_idx;
  logic [IDX_W-1:0]   lo_idx;
  logic [IDX_W-1:0]   win_idx;

  always_comb begin
    any_valid = 1'b0;
    hi_found  = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (in_req_valid[i] && !any_valid) begin
        any_valid = 1'b1;
        lo_idx    = IDX_W'(i);
      end
      if (in_req_valid[i] && !hi_found && (IDX_W'(i) >= rr_ptr_q)) begin
        hi_found = 1'b1;
        hi_idx   = IDX_W'(i);
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  // Mux the winner's request bundle.
  logic               sel_cached;
  logic               sel_aligned;
  logic               sel_func;
  logic [31:0]        sel_addr;
  logic [31:0]        sel_data;
  logic [3:0]         sel_wstrb;

  always_comb begin
    sel_cached  = 1'b0;
    sel_aligned = 1'b0;
    sel_func    = 1'b0;
    sel_addr    = '0;
    sel_data    = '0;
    sel_wstrb   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        sel_cached  = in_req_bits_is_cached[i];
        sel_aligned = in_req_bits_is_aligned[i];
        sel_func    = in_req_bits_func[i];
        sel_addr    = in_req_bits_addr[32*i +: 32];
        sel_data    = in_req_bits_data[32*i +: 32];
        sel_wstrb   = in_req_bits_wstrb[4*i +: 4];
      end
    end
  end

  // Upstream/downstream handshake signals. Every output is forced low while
  // reset is asserted, whatever state the flops still hold.
  logic               owner_resp_ready;
  logic               req_fire;
  logic               issue_fire;
  logic               resp_fire;

  always_comb begin
    in_req_ready     = '0;
    in_resp_valid    = '0;
    owner_resp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        owner_resp_ready = in_resp_ready[i];
      end
      in_req_ready[i]  = !reset && (state_q == IDLE) && any_valid &&
                         (win_idx == IDX_W'(i));
      in_resp_valid[i] = !reset && (state_q == WAIT) && out_resp_valid &&
                         (owner_q == IDX_W'(i));
    end
    in_resp_bits_data = out_resp_bits_data;
    out_req_valid     = !reset && (state_q == ISSUE);
    out_resp_ready    = !reset && (state_q == WAIT) && owner_resp_ready;
    req_fire          = (state_q == IDLE) && any_valid;
    issue_fire        = out_req_valid && out_req_ready;
    resp_fire         = out_resp_valid && out_resp_ready;
  end

  assign out_req_bits_is_cached  = cached_q;
  assign out_req_bits_is_aligned = aligned_q;
  assign out_req_bits_func       = func_q;
  assign out_req_bits_addr       = addr_q;
  assign out_req_bits_data       = data_q;
  assign out_req_bits_wstrb      = wstrb_q;

  // Next-state: accept in IDLE, hold the registered request through ISSUE,
  // then wait for the single response beat.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    cached_d  = cached_q;
    aligned_d = aligned_q;
    func_d    = func_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wstrb_d   = wstrb_q;
    unique case (state_q)
      IDLE: begin
        if (req_fire) begin
          state_d   = ISSUE;
          owner_d   = win_idx;
          rr_ptr_d  = (win_idx == IDX_W'(NREQ - 1)) ? '0 : (win_idx + IDX_W'(1));
          cached_d  = sel_cached;
          aligned_d = sel_aligned;
          func_d    = sel_func;
          addr_d    = sel_addr;
          data_d    = sel_data;
          wstrb_d   = sel_wstrb;
        end
      end
      ISSUE: begin
        if (issue_fire) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (resp_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      cached_q  <= 1'b0;
      aligned_q <= 1'b0;
      func_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      wstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      cached_q  <= cached_d;
      aligned_q <= aligned_d;
      func_q    <= func_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wstrb_q   <= wstrb_d;
    end
  end

endmodule

// File: tb/tb_sim_dev_arbiter.sv
// Testbench for sim_dev_arbiter: a two-requester instance for most scenarios
// and a three-requester instance for the wrap-around skip case.
module tb_sim_dev_arbiter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // NREQ=2 instance
  logic [1:0]  rq_ready, rq_valid, rq_cached, rq_aligned, rq_func, rs_ready, rs_valid;
  logic [63:0] rq_addr, rq_data;
  logic [7:0]  rq_wstrb;
  logic [31:0] rs_data;
  logic        oq_ready, oq_valid, oq_cached, oq_aligned, oq_func;
  logic [31:0] oq_addr, oq_data;
  logic [3:0]  oq_wstrb;
  logic        os_ready, os_valid;
  logic [31:0] os_data;

  // NREQ=3 instance
  logic [2:0]  rq3_ready, rq3_valid, rq3_cached, rq3_aligned, rq3_func, rs3_ready, rs3_valid;
  logic [95:0] rq3_addr, rq3_data;
  logic [11:0] rq3_wstrb;
  logic [31:0] rs3_data;
  logic        oq3_ready, oq3_valid, oq3_cached, oq3_aligned, oq3_func;
  logic [31:0] oq3_addr, oq3_data;
  logic [3:0]  oq3_wstrb;
  logic        os3_ready, os3_valid;
  logic [31:0] os3_data;

  sim_dev_arbiter #(.NREQ(2)) u_dut (
    .clock(clock), .reset(reset),
    .in_req_ready(rq_ready), .in_req_valid(rq_valid),
    .in_req_bits_is_cached(rq_cached), .in_req_bits_is_aligned(rq_aligned),
    .in_req_bits_addr(rq_addr), .in_req_bits_data(rq_data),
    .in_req_bits_func(rq_func), .in_req_bits_wstrb(rq_wstrb),
    .in_resp_ready(rs_ready), .in_resp_valid(rs_valid), .in_resp_bits_data(rs_data),
    .out_req_ready(oq_ready), .out_req_valid(oq_valid),
    .out_req_bits_is_cached(oq_cached), .out_req_bits_is_aligned(oq_aligned),
    .out_req_bits_func(oq_func), .out_req_bits_addr(oq_addr),
    .out_req_bits_data(oq_data), .out_req_bits_wstrb(oq_wstrb),
    .out_resp_ready(os_ready), .out_resp_valid(os_valid), .out_resp_bits_data(os_data)
  );

  sim_dev_arbiter #(.NREQ(3)) u_dut3 (
    .clock(clock), .reset(reset),
    .in_req_ready(rq3_ready), .in_req_valid(rq3_valid),
    .in_req_bits_is_cached(rq3_cached), .in_req_bits_is_aligned(rq3_aligned),
    .in_req_bits_addr(rq3_addr), .in_req_bits_data(rq3_data),
    .in_req_bits_func(rq3_func), .in_req_bits_wstrb(rq3_wstrb),
    .in_resp_ready(rs3_ready), .in_resp_valid(rs3_valid), .in_resp_bits_data(rs3_data),
    .out_req_ready(oq3_ready), .out_req_valid(oq3_valid),
    .out_req_bits_is_cached(oq3_cached), .out_req_bits_is_aligned(oq3_aligned),
    .out_req_bits_func(oq3_func), .out_req_bits_addr(oq3_addr),
    .out_req_bits_data(oq3_data), .out_req_bits_wstrb(oq3_wstrb),
    .out_resp_ready(os3_ready), .out_resp_valid(os3_valid), .out_resp_bits_data(os3_data)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    rq_valid = '0; rq_cached = '0; rq_aligned = '0; rq_func = '0;
    rq_addr = '0; rq_data = '0; rq_wstrb = '0; rs_ready = '0;
    oq_ready = 1'b0; os_valid = 1'b0; os_data = '0;
    rq3_valid = '0; rq3_cached = '0; rq3_aligned = '0; rq3_func = '0;
    rq3_addr = '0; rq3_data = '0; rq3_wstrb = '0; rs3_ready = '0;
    oq3_ready = 1'b0; os3_valid = 1'b0; os3_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reset while a request is latched: outputs low during reset, request
  // registers cleared, pointer back to 0.
  task automatic test_reset();
    do_reset();
    rq_valid = 2'b01;
    rq_addr  = {32'h0, 32'hAAAA_0000};
    rq_data  = {32'h0, 32'h5555_1234};
    rq_wstrb = 8'h0C;
    oq_ready = 1'b0;
    tick();
    reset = 1'b1;
    rq_valid = 2'b11;
    rs_ready = 2'b11;
    os_valid = 1'b1;
    oq_ready = 1'b1;
    settle();
    checks++; if (oq_valid !== 1'b0) begin errors++; $display("FAIL reset_oq_valid: got %b want 0", oq_valid); end
    checks++; if (rq_ready !== 2'b00) begin errors++; $display("FAIL reset_rq_ready: got %b want 00", rq_ready); end
    checks++; if (rs_valid !== 2'b00 || os_ready !== 1'b0) begin errors++; $display("FAIL reset_resp: got rs_valid=%b os_ready=%b want 00/0", rs_valid, os_ready); end
    tick();
    checks++; if ({oq_addr, oq_data, oq_wstrb} !== 68'h0) begin errors++; $display("FAIL reset_regs: got addr=%h data=%h wstrb=%h want 0", oq_addr, oq_data, oq_wstrb); end
    reset = 1'b0;
    os_valid = 1'b0;
    settle();
    checks++; if (rq_ready !== 2'b01) begin errors++; $display("FAIL reset_rr_ptr: got %b want 01", rq_ready); end
  endtask

  task automatic test_single();
    do_reset();
    rq_valid = 2'b10;
    rq_addr  = {32'h1000_0004, 32'h0};
    rq_data  = {32'hDEAD_BEEF, 32'h0};
    rq_func  = 2'b10;
    rq_wstrb = 8'hF0;
    rq_cached = 2'b10;
    oq_ready = 1'b1;
    rs_ready = 2'b11;
    settle();
    checks++; if (rq_ready !== 2'b10 || oq_valid !== 1'b0) begin errors++; $display("FAIL single_grant: got ready=%b oq_valid=%b want 10/0", rq_ready, oq_valid); end
    tick();
    rq_valid = 2'b00;
    settle();
    checks++; if (oq_valid !== 1'b1) begin errors++; $display("FAIL single_issue_valid: got %b want 1", oq_valid); end
    checks++;
    if ({oq_addr, oq_data, oq_wstrb, oq_func, oq_cached, oq_aligned} !== {32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL single_fields: got addr=%h data=%h wstrb=%h func=%b cached=%b aligned=%b want 10000004/deadbeef/f/1/1/0",
                         oq_addr, oq_data, oq_wstrb, oq_func, oq_cached, oq_aligned);
    end
    tick();
    settle();
    checks++; if (oq_valid !== 1'b0 || rs_valid !== 2'b00) begin errors++; $display("FAIL single_wait_quiet: got oq_valid=%b rs_valid=%b want 0/00", oq_valid, rs_valid); end
    os_valid = 1'b1;
    os_data  = 32'h0;
    settle();
    checks++; if (rs_valid !== 2'b10 || os_ready !== 1'b1) begin errors++; $display("FAIL single_resp: got rs_valid=%b os_ready=%b want 10/1", rs_valid, os_ready); end
    tick();
    os_valid = 1'b0;
    settle();
    checks++; if (rs_valid !== 2'b00) begin errors++; $display("FAIL single_resp_once: got %b want 00", rs_valid); end
    rq_valid = 2'b11;
    settle();
    checks++; if (rq_ready !== 2'b01) begin errors++; $display("FAIL single_rr_after: got %b want 01", rq_ready); end
  endtask

  task automatic test_rotation();
    int order [4] = '{0, 1, 0, 1};
    logic [31:0] addr_tbl [2] = '{32'hA000_0000, 32'hB000_0001};
    logic [31:0] d;
    do_reset();
    rq_valid = 2'b11;
    rq_addr  = {addr_tbl[1], addr_tbl[0]};
    oq_ready = 1'b1;
    rs_ready = 2'b11;
    for (int t = 0; t < 4; t++) begin
      settle();
      checks++; if (rq_ready !== 2'(1 << order[t])) begin errors++; $display("FAIL rotation_grant[%0d]: got %b want %b", t, rq_ready, 2'(1 << order[t])); end
      tick();
      settle();
      checks++; if (oq_addr !== addr_tbl[order[t]]) begin errors++; $display("FAIL rotation_addr[%0d]: got %h want %h", t, oq_addr, addr_tbl[order[t]]); end
      tick();
      d = $urandom;
      os_valid = 1'b1;
      os_data  = d;
      settle();
      checks++; if (rs_valid !== 2'(1 << order[t]) || rs_data !== d) begin errors++; $display("FAIL rotation_resp[%0d]: got %b/%h want %b/%h", t, rs_valid, rs_data, 2'(1 << order[t]), d); end
      tick();
      os_valid = 1'b0;
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    rq_valid = 2'b01;
    rq_addr  = {32'h0, 32'h2000_0000};
    oq_ready = 1'b0;
    settle();
    tick();
    for (int c = 0; c < 5; c++) begin
      rq_addr[31:0] = $urandom;
      rq_valid = 2'b11;
      settle();
      checks++; if (oq_addr !== 32'h2000_0000 || oq_valid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d]: got addr=%h valid=%b want 20000000/1", c, oq_addr, oq_valid); end
      checks++; if (rq_ready !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 00", c, rq_ready); end
      tick();
    end
    oq_ready = 1'b1;
    rq_valid = 2'b00;
    tick();
    oq_ready = 1'b0;
    settle();
    checks++; if (oq_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b want 0", oq_valid); end
    os_valid = 1'b1;
    rs_ready = 2'b11;
    tick();
    os_valid = 1'b0;
  endtask

  task automatic test_resp_back_pressure();
    do_reset();
    rq_valid = 2'b01;
    oq_ready = 1'b1;
    settle();
    tick();
    rq_valid = 2'b00;
    tick();
    os_valid = 1'b1;
    os_data  = 32'h1234_5678;
    rs_ready = 2'b10;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++; if (os_ready !== 1'b0 || rs_valid !== 2'b01 || rs_data !== 32'h1234_5678) begin
        errors++; $display("FAIL rbp_stall[%0d]: got os_ready=%b rs_valid=%b data=%h want 0/01/12345678", c, os_ready, rs_valid, rs_data);
      end
      tick();
    end
    rs_ready = 2'b01;
    settle();
    checks++; if (os_ready !== 1'b1) begin errors++; $display("FAIL rbp_accept: got %b want 1", os_ready); end
    tick();
    os_valid = 1'b0;
    rq_valid = 2'b11;
    settle();
    checks++; if (rq_ready !== 2'b10) begin errors++; $display("FAIL rbp_idle_after: got %b want 10", rq_ready); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rq_valid = 2'b01;
    oq_ready = 1'b1;
    settle();
    tick();
    rq_valid = 2'b00;
    tick();
    rs_ready = 2'b11;
    reset = 1'b1;
    settle();
    checks++; if (rs_valid !== 2'b00 || os_ready !== 1'b0) begin errors++; $display("FAIL rmid_during: got rs_valid=%b os_ready=%b want 00/0", rs_valid, os_ready); end
    tick();
    reset = 1'b0;
    os_valid = 1'b1;
    os_data  = 32'hCAFE_F00D;
    for (int c = 0; c < 2; c++) begin
      settle();
      checks++; if (rs_valid !== 2'b00 || os_ready !== 1'b0) begin errors++; $display("FAIL rmid_late_resp[%0d]: got rs_valid=%b os_ready=%b want 00/0", c, rs_valid, os_ready); end
      tick();
    end
    os_valid = 1'b0;
    rq_valid = 2'b11;
    settle();
    checks++; if (rq_ready !== 2'b01) begin errors++; $display("FAIL rmid_next_grant: got %b want 01", rq_ready); end
  endtask

  task automatic test_nreq3_skip();
    do_reset();
    rq3_valid = 3'b001;
    oq3_ready = 1'b1;
    rs3_ready = 3'b111;
    settle();
    checks++; if (rq3_ready !== 3'b001) begin errors++; $display("FAIL skip3_first: got %b want 001", rq3_ready); end
    tick();
    rq3_valid = 3'b000;
    tick();
    os3_valid = 1'b1;
    tick();
    os3_valid = 1'b0;
    rq3_valid = 3'b101;
    rq3_addr  = {32'h2222_0000, 32'h1111_0000, 32'h0000_0000};
    settle();
    checks++; if (rq3_ready !== 3'b100) begin errors++; $display("FAIL skip3_req2: got %b want 100", rq3_ready); end
    tick();
    settle();
    checks++; if (oq3_addr !== 32'h2222_0000) begin errors++; $display("FAIL skip3_addr: got %h want 22220000", oq3_addr); end
    tick();
    os3_valid = 1'b1;
    settle();
    checks++; if (rs3_valid !== 3'b100) begin errors++; $display("FAIL skip3_resp: got %b want 100", rs3_valid); end
    tick();
    os3_valid = 1'b0;
    settle();
    checks++; if (rq3_ready !== 3'b001) begin errors++; $display("FAIL skip3_wrap: got %b want 001", rq3_ready); end
  endtask

  // Random transactions against a transaction-level model: the model keeps
  // only the round-robin pointer and picks the first valid requester at or
  // after it, modulo NREQ.
  task automatic test_random();
    int          model_rr;
    int          w;
    int          dly;
    logic [1:0]  vals;
    logic [1:0]  onehot;
    logic [70:0] exp_req;
    logic [31:0] d;
    do_reset();
    model_rr = 0;
    for (int n = 0; n < 40; n++) begin
      vals       = 2'($urandom_range(1, 3));
      rq_valid   = vals;
      rq_addr    = {$urandom, $urandom};
      rq_data    = {$urandom, $urandom};
      rq_wstrb   = 8'($urandom);
      rq_func    = 2'($urandom);
      rq_cached  = 2'($urandom);
      rq_aligned = 2'($urandom);
      rs_ready   = 2'b00;
      w = -1;
      for (int k = 0; k < 2; k++) begin
        if (w < 0 && vals[(model_rr + k) % 2]) w = (model_rr + k) % 2;
      end
      onehot  = 2'(1 << w);
      exp_req = {rq_addr[32*w +: 32], rq_data[32*w +: 32], rq_wstrb[4*w +: 4],
                 rq_func[w], rq_cached[w], rq_aligned[w]};
      settle();
      checks++; if (rq_ready !== onehot) begin errors++; $display("FAIL rand_grant[%0d]: got %b want %b", n, rq_ready, onehot); end
      tick();
      dly = $urandom_range(0, 3);
      for (int c = 0; c <= dly; c++) begin
        rq_valid = 2'($urandom);
        rq_addr  = {$urandom, $urandom};
        oq_ready = (c == dly);
        settle();
        checks++;
        if (oq_valid !== 1'b1 || rq_ready !== 2'b00 ||
            {oq_addr, oq_data, oq_wstrb, oq_func, oq_cached, oq_aligned} !== exp_req) begin
          errors++; $display("FAIL rand_issue[%0d]: got valid=%b ready=%b req=%h want 1/00/%h", n, oq_valid, rq_ready,
                             {oq_addr, oq_data, oq_wstrb, oq_func, oq_cached, oq_aligned}, exp_req);
        end
        tick();
      end
      oq_ready = 1'b0;
      dly = $urandom_range(0, 2);
      for (int c = 0; c < dly; c++) begin
        os_valid = 1'b0;
        rs_ready = 2'($urandom);
        settle();
        checks++; if (rs_valid !== 2'b00) begin errors++; $display("FAIL rand_wait_quiet[%0d]: got %b want 00", n, rs_valid); end
        tick();
      end
      d = $urandom;
      os_valid = 1'b1;
      os_data  = d;
      dly = $urandom_range(0, 2);
      for (int c = 0; c <= dly; c++) begin
        rs_ready    = 2'($urandom);
        rs_ready[w] = (c == dly);
        settle();
        checks++;
        if (rs_valid !== onehot || rs_data !== d || os_ready !== (c == dly)) begin
          errors++; $display("FAIL rand_resp[%0d]: got valid=%b data=%h os_ready=%b want %b/%h/%b", n, rs_valid, rs_data, os_ready, onehot, d, (c == dly));
        end
        tick();
      end
      os_valid = 1'b0;
      model_rr = (w + 1) % 2;
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_rotation();
    test_back_pressure();
    test_resp_back_pressure();
    test_reset_mid();
    test_nreq3_skip();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sim_dev_arbiter.md
Name: sim_dev_arbiter

Overview:
- Round-robin arbiter that shares a single SimDev-style device port (req/resp bundle) among NREQ upstream requesters, such as the instruction fetch, data memory and MMIO paths.
- Allows exactly one outstanding transaction.
- Registers the winning request, issues it downstream, and routes the single-beat response back to its owner.
- Sits between the core-side memory clients and the simulated device or memory model.

Parameters:
- NREQ, 2, number of upstream requesters (2..8).
- IDX_W, clog2(NREQ) (min 1), width of the owner index and the round-robin pointer (derived, not overridden).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- in_req_ready  out  NREQ  per-requester request ready.
- in_req_valid  in  NREQ  per-requester request valid.
- in_req_bits_is_cached  in  NREQ  per-requester cached flag.
- in_req_bits_is_aligned  in  NREQ  per-requester aligned flag.
- in_req_bits_addr  in  32*NREQ  address, requester i at bits [32i+31:32i].
- in_req_bits_data  in  32*NREQ  write data, same packing.
- in_req_bits_func  in  NREQ  0=read, 1=write.
- in_req_bits_wstrb  in  4*NREQ  byte strobes.
- in_resp_ready  in  NREQ  per-requester response ready.
- in_resp_valid  out  NREQ  per-requester response valid.
- in_resp_bits_data  out  32  shared response data, qualified by in_resp_valid.
- out_req_ready  in  1  device accepts request.
- out_req_valid  out  1  request to device.
- out_req_bits_is_cached, out_req_bits_is_aligned, out_req_bits_func  out  1 each  registered request fields.
- out_req_bits_addr, out_req_bits_data  out  32 each  registered request fields.
- out_req_bits_wstrb  out  4  registered byte strobes.
- out_resp_ready  out  1  arbiter accepts response.
- out_resp_valid  in  1  device response valid.
- out_resp_bits_data  in  32  device response data.

Behaviour:
- **States:** IDLE, ISSUE, WAIT. State, owner, the rr pointer and all request registers are flops.
- **Reset** (synchronous, active-high, wins over any other event):
  - state=IDLE, rr_ptr=0, owner=0, request registers=0.
  - All outputs low: in_req_ready=0, in_resp_valid=0, out_req_valid=0, out_resp_ready=0.
  - Reset mid-transaction drops the transaction. No response is delivered to the owner, and a late out_resp_valid after reset is ignored, because state is IDLE.
- **IDLE:**
  - Winner = first i with in_req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - in_req_ready[winner]=1 combinationally; all other bits are 0. No requester is ready if none is valid.
  - On handshake: latch the winner's bundle into the out_req_* registers, owner<=winner, rr_ptr<=(winner+1) mod NREQ, then go to ISSUE.
  - in_req_ready depends only on state and in_req_valid. It never depends on out_* signals.
- **ISSUE:**
  - out_req_valid=1 with the registered fields, held stable until out_req_ready.
  - When out_req_valid && out_req_ready, go to WAIT.
  - First possible downstream valid is 1 cycle after upstream acceptance.
- **WAIT:**
  - in_resp_valid[owner]=out_resp_valid; all other bits are 0.
  - in_resp_bits_data=out_resp_bits_data, passed through combinationally.
  - out_resp_ready=in_resp_ready[owner].
  - On out_resp_valid && out_resp_ready, go to IDLE. A new request can be accepted the following cycle.
  - The device may return the response in the same cycle ISSUE completes. It is not accepted until the arbiter is in WAIT. The device holds it valid, per the device-port contract.
- **Writes:** writes also receive exactly one response beat, with data ignored by the requester.
- **Fairness:** with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0,... Each requester waits at most NREQ-1 transactions.
- **Outside the granted index:** in_req_valid changes on non-granted indices during ISSUE or WAIT have no effect. in_req_ready stays 0 outside IDLE.
- **Unused outputs:** in_resp_bits_data is don't-care when no in_resp_valid is set; drive it from out_resp_bits_data unconditionally. out_resp_ready=0 outside WAIT.

Test Plan:
- **Single requester:**
  - Stimulus: req1 valid, addr=0x1000_0004, func=1, wstrb=0xF, data=0xDEADBEEF. The device is ready immediately and responds 1 cycle later.
  - Required: out_req_valid rises 1 cycle after in_req_ready[1]; fields match exactly; in_resp_valid[1] pulses once; rr_ptr=0 afterwards.
- **Contention rotation:**
  - Stimulus: both requesters valid for 4 transactions from reset.
  - Required: grant order is 0,1,0,1; in_resp_valid goes only to the owner each time.
- **Downstream backpressure:**
  - Stimulus: out_req_ready held 0 for 5 cycles in ISSUE while req0 changes its addr input.
  - Required: out_req_bits_addr stays at the latched value; in_req_ready stays 0 throughout.
- **Upstream response backpressure:**
  - Stimulus: device returns data 0x12345678, and in_resp_ready[owner]=0 for 3 cycles.
  - Required: out_resp_ready=0 for those 3 cycles; the handshake completes on the 4th cycle; IDLE follows.
- **Reset mid-transaction:**
  - Stimulus: reset asserted for 1 cycle in WAIT, then the device raises out_resp_valid.
  - Required: no in_resp_valid asserted; out_resp_ready=0; the next grant goes to requester 0 (rr_ptr=0).
- **NREQ=3 skip:**
  - Stimulus: rr_ptr=1, only req0 and req2 valid.
  - Required: req2 is granted first and rr_ptr becomes 0; req0 is granted next.
